// File: rtl/camera_pixel_capture_if.sv
// ---------------------------------------------------------------------------
// camera_pixel_capture_if
//   Pixel stream from the capture stage to the Bayer picture maker.
//
//   Handshake: valid-only. pixeldata_flag is high for exactly one sysClk
//   cycle per pixel, and dozen_out is valid in that cycle. There is no
//   ready signal: the consumer must take every strobe. dozen_out holds its
//   value between strobes.
//
//   Signals:
//     dozen_out       [DW-1:0]  captured pixel
//     pixeldata_flag            one-cycle strobe qualifying dozen_out
//   Modports:
//     master  - capture stage (drives the stream)
//     slave   - picture maker (observes the stream)
// ---------------------------------------------------------------------------
interface camera_pixel_capture_if #(
   parameter int DW = 12
);
   logic [DW-1:0] dozen_out;
   logic          pixeldata_flag;

   modport master (output dozen_out, output pixeldata_flag);
   modport slave  (input  dozen_out, input  pixeldata_flag);
endinterface

// File: rtl/camera_pixel_capture.sv
// ---------------------------------------------------------------------------
// camera_pixel_capture
//   Front-end capture for a 12-bit parallel image-sensor port. The sensor
//   pixel clock, fval, lval and data are synchronized into sysClk. One whole
//   frame is captured per arm request, and each accepted pixel is emitted as
//   a strobe on the pixel stream. Frame geometry is checked against
//   COLS x ROWS, and start/done/error status is reported.
//
//   Ports:
//     sysClk, sysRst_n   system clock, async active-low reset
//     cam_pixclk         sensor pixel clock (sampled as data)
//     cam_fval, cam_lval sensor frame / line valid
//     cam_data           sensor pixel data
//     capture_en         one-cycle arm request (honoured only in IDLE)
//     pix_out            pixel stream (dozen_out / pixeldata_flag)
//     frame_start        pulse at first fval=1 sample after arming
//     frame_done         pulse at end of captured frame
//     frame_error        sticky geometry error of last frame
//     busy               state != IDLE
//     row_count          completed lines in current frame
//     col_count          pixels accepted in current line
//     state_dbg          FSM state (IDLE=0, ARMED=1, WAIT_FV=2, ACTIVE=3)
//     sync_dbg           {fval, lval} synchronizer third stage
// ---------------------------------------------------------------------------
module camera_pixel_capture #(
   parameter int COLS = 2592,
   parameter int ROWS = 1944,
   parameter int DW   = 12
) (
   input  logic                  sysClk,
   input  logic                  sysRst_n,
   input  logic                  cam_pixclk,
   input  logic                  cam_fval,
   input  logic                  cam_lval,
   input  logic [DW-1:0]         cam_data,
   input  logic                  capture_en,
   camera_pixel_capture_if.master pix_out,
   output logic                  frame_start,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic                  busy,
   output logic [10:0]           row_count,
   output logic [11:0]           col_count,
   output logic [1:0]            state_dbg,
   output logic [1:0]            sync_dbg
);

   localparam logic [11:0] COLS_W = COLS[11:0];
   localparam logic [10:0] ROWS_W = ROWS[10:0];

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      WAIT_FV = 2'd2,
      ACTIVE  = 2'd3
   } state_t;

   // ---------------- synchronizers ----------------
   logic          pix_q1, pix_q2, pix_q3;
   logic          fv_q1,  fv_q2,  fv_q3;
   logic          lv_q1,  lv_q2,  lv_q3;
   logic [DW-1:0] data_q1, data_q2;

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         pix_q1  <= 1'b0;
         pix_q2  <= 1'b0;
         pix_q3  <= 1'b0;
         fv_q1   <= 1'b0;
         fv_q2   <= 1'b0;
         fv_q3   <= 1'b0;
         lv_q1   <= 1'b0;
         lv_q2   <= 1'b0;
         lv_q3   <= 1'b0;
         data_q1 <= '0;
         data_q2 <= '0;
      end else begin
         pix_q1  <= cam_pixclk;
         pix_q2  <= pix_q1;
         pix_q3  <= pix_q2;
         fv_q1   <= cam_fval;
         fv_q2   <= fv_q1;
         fv_q3   <= fv_q2;
         lv_q1   <= cam_lval;
         lv_q2   <= lv_q1;
         lv_q3   <= lv_q2;
         data_q1 <= cam_data;
         data_q2 <= data_q1;
      end
   end

   // Rising pixel-clock edge seen in the sysClk domain. The sample is
   // taken from stage 2, which is aligned with the edge detection.
   logic          pe;
   logic          fv_smp, lv_smp;
   logic [DW-1:0] data_smp;

   assign pe       = pix_q2 & ~pix_q3;
   assign fv_smp   = fv_q2;
   assign lv_smp   = lv_q2;
   assign data_smp = data_q2;
   assign sync_dbg = {fv_q3, lv_q3};

   // ---------------- FSM and datapath registers ----------------
   state_t        state_q, state_n;
   logic [11:0]   col_q, col_n;
   logic [10:0]   row_q, row_n;
   logic          err_q, err_n;
   logic          prev_lv_q, prev_lv_n;
   logic          frame_error_q, frame_error_n;
   logic [DW-1:0] dozen_q, dozen_n;
   logic          flag_q, flag_n;
   logic          start_q, start_n;
   logic          done_q, done_n;

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         state_q       <= IDLE;
         col_q         <= '0;
         row_q         <= '0;
         err_q         <= 1'b0;
         prev_lv_q     <= 1'b0;
         frame_error_q <= 1'b0;
         dozen_q       <= '0;
         flag_q        <= 1'b0;
         start_q       <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_n;
         col_q         <= col_n;
         row_q         <= row_n;
         err_q         <= err_n;
         prev_lv_q     <= prev_lv_n;
         frame_error_q <= frame_error_n;
         dozen_q       <= dozen_n;
         flag_q        <= flag_n;
         start_q       <= start_n;
         done_q        <= done_n;
      end
   end

   // Working copies of the frame counters. On the fval=1 sample that leaves
   // WAIT_FV they start from zero, so that same sample is handled exactly
   // like any ACTIVE sample below.
   logic [11:0] col_v;
   logic [10:0] row_v;
   logic        err_v;
   logic        lv_prev_v;
   logic        process_smp;
   logic        line_fall;

   always_comb begin
      state_n       = state_q;
      col_n         = col_q;
      row_n         = row_q;
      err_n         = err_q;
      prev_lv_n     = prev_lv_q;
      frame_error_n = frame_error_q;
      dozen_n       = dozen_q;
      flag_n        = 1'b0;
      start_n       = 1'b0;
      done_n        = 1'b0;
      col_v         = col_q;
      row_v         = row_q;
      err_v         = err_q;
      lv_prev_v     = prev_lv_q;
      process_smp   = 1'b0;
      line_fall     = 1'b0;

      case (state_q)
         IDLE: begin
            if (capture_en) begin
               state_n       = ARMED;
               frame_error_n = 1'b0;
            end
         end
         // Wait for a frame gap so a frame already in flight is skipped.
         ARMED: begin
            if (pe && !fv_smp) begin
               state_n = WAIT_FV;
            end
         end
         WAIT_FV: begin
            if (pe && fv_smp) begin
               start_n     = 1'b1;
               col_v       = '0;
               row_v       = '0;
               err_v       = 1'b0;
               lv_prev_v   = 1'b0;
               process_smp = 1'b1;
            end
         end
         ACTIVE: begin
            process_smp = pe;
         end
         default: state_n = IDLE;
      endcase

      if (process_smp) begin
         // A line ends when lval drops, or when fval drops while lval was
         // still high; the line-length check runs before the frame check.
         line_fall = lv_prev_v && !(fv_smp && lv_smp);
         if (line_fall) begin
            if (col_v != COLS_W) begin
               err_v = 1'b1;
            end
            if (row_v < ROWS_W) begin
               row_v = row_v + 11'd1;
            end
            col_v = '0;
         end

         if (fv_smp) begin
            state_n = ACTIVE;
            if (lv_smp) begin
               if ((col_v < COLS_W) && (row_v < ROWS_W)) begin
                  dozen_n = data_smp;
                  flag_n  = 1'b1;
                  col_v   = col_v + 12'd1;
               end else begin
                  err_v = 1'b1;
               end
            end
            prev_lv_n = lv_smp;
         end else begin
            if (row_v != ROWS_W) begin
               err_v = 1'b1;
            end
            done_n        = 1'b1;
            frame_error_n = err_v;
            prev_lv_n     = 1'b0;
            state_n       = IDLE;
         end

         col_n = col_v;
         row_n = row_v;
         err_n = err_v;
      end
   end

   assign pix_out.dozen_out      = dozen_q;
   assign pix_out.pixeldata_flag = flag_q;
   assign frame_start            = start_q;
   assign frame_done             = done_q;
   assign frame_error            = frame_error_q;
   assign busy                   = (state_q != IDLE);
   assign row_count              = row_q;
   assign col_count              = col_q;
   assign state_dbg              = state_q;

endmodule

// File: tb/tb_camera_pixel_capture.sv
module tb_camera_pixel_capture;
   localparam int COLS = 8;
   localparam int ROWS = 4;
   localparam int DW   = 12;

   // ---------------- clock / reset ----------------
   logic          sysClk     = 1'b0;
   logic          sysRst_n   = 1'b0;
   logic          cam_pixclk = 1'b0;
   logic          cam_fval   = 1'b0;
   logic          cam_lval   = 1'b0;
   logic [DW-1:0] cam_data   = '0;
   logic          capture_en = 1'b0;
   logic          frame_start, frame_done, frame_error, busy;
   logic [10:0]   row_count;
   logic [11:0]   col_count;
   logic [1:0]    state_dbg, sync_dbg;

   camera_pixel_capture_if #(.DW(DW)) pix_if ();

   camera_pixel_capture #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
      .sysClk      (sysClk),
      .sysRst_n    (sysRst_n),
      .cam_pixclk  (cam_pixclk),
      .cam_fval    (cam_fval),
      .cam_lval    (cam_lval),
      .cam_data    (cam_data),
      .capture_en  (capture_en),
      .pix_out     (pix_if),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .frame_error (frame_error),
      .busy        (busy),
      .row_count   (row_count),
      .col_count   (col_count),
      .state_dbg   (state_dbg),
      .sync_dbg    (sync_dbg)
   );

   always #5 sysClk = ~sysClk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge sysClk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard monitor ----------------
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] exp_q[$];
   int            start_cnt = 0;
   int            done_cnt  = 0;
   int            strobe_cyc = 0;
   int            start_cyc  = 0;
   logic          err_at_done  = 1'b0;
   logic          busy_at_done = 1'b0;

   always @(posedge sysClk) begin
      #1;
      if (pix_if.pixeldata_flag) begin
         got_q.push_back(pix_if.dozen_out);
         strobe_cyc = cyc;
      end
      if (frame_start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (frame_done) begin
         done_cnt++;
         err_at_done  = frame_error;
         busy_at_done = busy;
      end
   end

   int line_len[8];

   // ---------------- driver tasks ----------------
   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      start_cnt = 0;
      done_cnt  = 0;
   endtask

   // One pixel clock period: 3 sysClk low, then 3 sysClk high.
   task automatic drive_pix(input logic fv, input logic lv, input logic [DW-1:0] d,
                            input logic arm);
      @(negedge sysClk);
      cam_fval   = fv;
      cam_lval   = lv;
      cam_data   = d;
      cam_pixclk = 1'b0;
      capture_en = arm;
      @(negedge sysClk);
      capture_en = 1'b0;
      @(negedge sysClk);
      @(negedge sysClk);
      cam_pixclk = 1'b1;
      repeat (2) @(negedge sysClk);
   endtask

   task automatic arm();
      @(negedge sysClk);
      capture_en = 1'b1;
      @(negedge sysClk);
      capture_en = 1'b0;
   endtask

   task automatic drive_frame(input int nrows, input int arm_row, input int arm_col);
      repeat (2) drive_pix(1'b0, 1'b0, '0, 1'b0);
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < line_len[r]; c++) begin
            drive_pix(1'b1, 1'b1, DW'(r * 16 + c), (r == arm_row) && (c == arm_col));
         end
         repeat (2) drive_pix(1'b1, 1'b0, '0, 1'b0);
      end
      repeat (2) drive_pix(1'b0, 1'b0, '0, 1'b0);
      repeat (4) @(negedge sysClk);
   endtask

   task automatic set_lines(input int l0, input int l1, input int l2, input int l3);
      line_len[0] = l0;
      line_len[1] = l1;
      line_len[2] = l2;
      line_len[3] = l3;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #3;
      n_vec++; if (pix_if.pixeldata_flag !== 1'b0) begin n_err++; $display("FAIL rst_flag got=%b exp=0", pix_if.pixeldata_flag); end
      n_vec++; if (pix_if.dozen_out !== '0) begin n_err++; $display("FAIL rst_dozen got=%h exp=0", pix_if.dozen_out); end
      n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_start got=%b exp=0", frame_start); end
      n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", frame_done); end
      n_vec++; if (frame_error !== 1'b0) begin n_err++; $display("FAIL rst_error got=%b exp=0", frame_error); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_vec++; if (row_count !== 11'd0) begin n_err++; $display("FAIL rst_row got=%0d exp=0", row_count); end
      n_vec++; if (col_count !== 12'd0) begin n_err++; $display("FAIL rst_col got=%0d exp=0", col_count); end
      n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
      repeat (3) @(negedge sysClk);
      sysRst_n = 1'b1;
      repeat (3) @(negedge sysClk);
   endtask

   task automatic test_nominal();
      clear_mon();
      set_lines(8, 8, 8, 8);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++) exp_q.push_back(DW'(r * 16 + c));
      arm();
      drive_frame(4, -1, -1);
      n_vec++; if (got_q.size() !== 32) begin n_err++; $display("FAIL nom_count got=%0d exp=32", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL nom_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      n_vec++; if (start_cnt !== 1) begin n_err++; $display("FAIL nom_starts got=%0d exp=1", start_cnt); end
      n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL nom_dones got=%0d exp=1", done_cnt); end
      n_vec++; if (err_at_done !== 1'b0) begin n_err++; $display("FAIL nom_error got=%b exp=0", err_at_done); end
      n_vec++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL nom_busy_at_done got=%b exp=0", busy_at_done); end
      n_vec++; if (row_count !== 11'd4) begin n_err++; $display("FAIL nom_rows got=%0d exp=4", row_count); end
   endtask

   task automatic test_arm_mid_frame();
      clear_mon();
      set_lines(8, 8, 8, 8);
      drive_frame(4, 2, 3);
      n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL mid_partial_count got=%0d exp=0", got_q.size()); end
      n_vec++; if (start_cnt !== 0) begin n_err++; $display("FAIL mid_partial_start got=%0d exp=0", start_cnt); end
      n_vec++; if (state_dbg !== 2'd2) begin n_err++; $display("FAIL mid_wait_state got=%0d exp=2", state_dbg); end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++) exp_q.push_back(DW'(r * 16 + c));
      drive_frame(4, -1, -1);
      n_vec++; if (got_q.size() !== 32) begin n_err++; $display("FAIL mid_count got=%0d exp=32", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL mid_dones got=%0d exp=1", done_cnt); end
      n_vec++; if (err_at_done !== 1'b0) begin n_err++; $display("FAIL mid_error got=%b exp=0", err_at_done); end
   endtask

   task automatic test_short_long();
      clear_mon();
      set_lines(8, 7, 9, 8);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < line_len[r] && c < 8; c++) exp_q.push_back(DW'(r * 16 + c));
      arm();
      drive_frame(4, -1, -1);
      n_vec++; if (got_q.size() !== 31) begin n_err++; $display("FAIL sl_count got=%0d exp=31", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sl_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      n_vec++; if (err_at_done !== 1'b1) begin n_err++; $display("FAIL sl_error_at_done got=%b exp=1", err_at_done); end
      n_vec++; if (frame_error !== 1'b1) begin n_err++; $display("FAIL sl_error_sticky got=%b exp=1", frame_error); end
      // A following good frame clears the error.
      clear_mon();
      arm();
      n_vec++; if (frame_error !== 1'b0) begin n_err++; $display("FAIL sl_arm_clear got=%b exp=0", frame_error); end
      set_lines(8, 8, 8, 8);
      drive_frame(4, -1, -1);
      n_vec++; if (got_q.size() !== 32) begin n_err++; $display("FAIL sl_good_count got=%0d exp=32", got_q.size()); end
      n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL sl_good_dones got=%0d exp=1", done_cnt); end
      n_vec++; if (err_at_done !== 1'b0) begin n_err++; $display("FAIL sl_good_error got=%b exp=0", err_at_done); end
   endtask

   task automatic test_early_fval();
      clear_mon();
      set_lines(8, 8, 8, 8);
      arm();
      drive_frame(3, -1, -1);
      n_vec++; if (got_q.size() !== 24) begin n_err++; $display("FAIL early_count got=%0d exp=24", got_q.size()); end
      n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL early_dones got=%0d exp=1", done_cnt); end
      n_vec++; if (err_at_done !== 1'b1) begin n_err++; $display("FAIL early_error got=%b exp=1", err_at_done); end
      n_vec++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL early_busy got=%b exp=0", busy_at_done); end
      n_vec++; if (row_count !== 11'd3) begin n_err++; $display("FAIL early_rows got=%0d exp=3", row_count); end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      set_lines(8, 8, 8, 8);
      arm();
      fork
         drive_frame(4, -1, -1);
         begin
            int t = 0;
            while (got_q.size() < 10 && t < 3000) begin
               @(negedge sysClk);
               t++;
            end
            n_vec++;
            if (got_q.size() < 10) begin n_err++; $display("FAIL rm_timeout got=%0d exp=10", got_q.size()); end
            #2;
            sysRst_n = 1'b0;
            #1;
            n_vec++; if (pix_if.dozen_out !== '0) begin n_err++; $display("FAIL rm_dozen got=%h exp=0", pix_if.dozen_out); end
            n_vec++; if (pix_if.pixeldata_flag !== 1'b0) begin n_err++; $display("FAIL rm_flag got=%b exp=0", pix_if.pixeldata_flag); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got=%b exp=0", busy); end
            n_vec++; if (row_count !== 11'd0) begin n_err++; $display("FAIL rm_row got=%0d exp=0", row_count); end
            n_vec++; if (col_count !== 12'd0) begin n_err++; $display("FAIL rm_col got=%0d exp=0", col_count); end
            n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rm_state got=%0d exp=0", state_dbg); end
            repeat (3) @(negedge sysClk);
            sysRst_n = 1'b1;
         end
      join
      repeat (10) @(negedge sysClk);
      n_vec++; if (got_q.size() !== 10) begin n_err++; $display("FAIL rm_after_count got=%0d exp=10", got_q.size()); end
      n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL rm_dones got=%0d exp=0", done_cnt); end
      n_vec++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL rm_final_state got=%0d exp=0", state_dbg); end
   endtask

   task automatic test_latency();
      int n0;
      clear_mon();
      arm();
      drive_pix(1'b0, 1'b0, '0, 1'b0);
      @(negedge sysClk);
      cam_fval   = 1'b1;
      cam_lval   = 1'b1;
      cam_data   = 12'hABC;
      cam_pixclk = 1'b0;
      repeat (3) @(negedge sysClk);
      n0 = cyc;
      cam_pixclk = 1'b1;
      repeat (4) @(negedge sysClk);
      n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL lat_count got=%0d exp=1", got_q.size()); end
      n_vec++; if (strobe_cyc !== n0 + 3) begin n_err++; $display("FAIL lat_strobe_cycle got=%0d exp=%0d", strobe_cyc, n0 + 3); end
      n_vec++; if (start_cyc !== n0 + 3) begin n_err++; $display("FAIL lat_start_cycle got=%0d exp=%0d", start_cyc, n0 + 3); end
      n_vec++; if (pix_if.dozen_out !== 12'hABC) begin n_err++; $display("FAIL lat_data got=%h exp=abc", pix_if.dozen_out); end
      n_vec++; if (state_dbg !== 2'd3) begin n_err++; $display("FAIL lat_active got=%0d exp=3", state_dbg); end
      arm();
      @(negedge sysClk);
      n_vec++; if (state_dbg !== 2'd3) begin n_err++; $display("FAIL lat_arm_busy got=%0d exp=3", state_dbg); end
      drive_pix(1'b1, 1'b0, '0, 1'b0);
      drive_pix(1'b0, 1'b0, '0, 1'b0);
      repeat (4) @(negedge sysClk);
      n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL lat_dones got=%0d exp=1", done_cnt); end
      n_vec++; if (err_at_done !== 1'b1) begin n_err++; $display("FAIL lat_error got=%b exp=1", err_at_done); end
      n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL lat_final_count got=%0d exp=1", got_q.size()); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_arm_mid_frame();
      test_short_long();
      test_early_fval();
      test_reset_mid();
      test_latency();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
